// File: rtl/seven_segment_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_segment_scanner                                           |
// | Purpose  : N-digit multiplexed seven-segment driver. Scans active-low      |
// |            anodes, decodes each digit's hex nibble to active-low segments, |
// |            and takes new display data through a shadow register that is    |
// |            promoted only at frame boundaries, so no frame mixes old and    |
// |            new digits. Per-digit enable, decimal points, and optional PWM  |
// |            brightness dimming.                                             |
// | Options  : SEVSEG_PWM_EN - when defined, each anode is lit only while the  |
// |            sub-step counter is <= bright. When undefined, bright is        |
// |            ignored and every enabled anode is lit for its whole slot.      |
// | Params   : NUM_DIGITS (1..16) digits scanned                               |
// |            DIV (>=1) clk cycles per sub-step; one digit slot = 16*DIV      |
// | Ports    : clk          in  system clock, rising edge                      |
// |            reset        in  synchronous active-low reset                   |
// |            value        in  hex nibbles, digit i = value[4i+3:4i]          |
// |            dp_in        in  decimal point per digit, 1 = lit               |
// |            digit_en     in  1 = digit may light (sampled live)             |
// |            load         in  1-cycle strobe: capture value/dp_in            |
// |            bright       in  duty level 0..15 (PWM builds only)             |
// |            anode        out active-low anode select, bit i = digit i       |
// |            seg          out active-low segments {g,f,e,d,c,b,a}            |
// |            dp_n         out active-low decimal point                       |
// |            frame_start  out 1-cycle pulse in the cycle the index wraps     |
// |            pending      out shadow holds data not yet displayed            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 7813
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] c_PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] c_IDX_MAX   = IW'(NUM_DIGITS - 1);

  // Timing counters
  logic [PW-1:0] r_presc;
  logic [3:0]    r_sub;
  logic [IW-1:0] r_idx;

  // Display data: active is what is shown, shadow holds the next frame's data
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_pending;

  // Registered display outputs
  logic [NUM_DIGITS-1:0] r_anode;
  logic [6:0]            r_seg;
  logic                  r_dp_n;

  logic                  w_tick;
  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic                  w_gate;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic [NUM_DIGITS-1:0] w_anode_nxt;

  // --------------------------------------------------------------------------
  // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Scan timing: prescaler -> 16 sub-steps -> digit index
  // --------------------------------------------------------------------------
  assign w_tick       = (r_presc == c_PRESC_MAX);
  assign w_slot_wrap  = w_tick && (r_sub == 4'hF);
  assign w_frame_wrap = w_slot_wrap && (r_idx == c_IDX_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc <= '0;
      r_sub   <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : (r_presc + PW'(1));
      if (w_tick) begin
        r_sub <= r_sub + 4'd1;   // 4-bit counter wraps 15 -> 0 on its own
      end
      if (w_slot_wrap) begin
        // Explicit wrap so non-power-of-two digit counts never overrun
        r_idx <= (r_idx == c_IDX_MAX) ? '0 : (r_idx + IW'(1));
      end
    end
  end

  // frame_start is decoded from registered counter state, so it is clean.
  // Gated with reset so it stays low while reset is held.
  assign frame_start = w_frame_wrap & reset;

  // --------------------------------------------------------------------------
  // Shadow / active data path. Promotion happens on the same edge that the
  // index wraps to 0, so the first slot of the new frame already uses the new
  // data. A load on that same edge bypasses the shadow: it is the newest data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_pending <= 1'b0;
    end else if (w_frame_wrap && load) begin
      r_act_val <= value;
      r_act_dp  <= dp_in;
      r_pending <= 1'b0;
    end else if (w_frame_wrap && r_pending) begin
      r_act_val <= r_sh_val;
      r_act_dp  <= r_sh_dp;
      r_pending <= 1'b0;
    end else if (load) begin
      r_sh_val  <= value;
      r_sh_dp   <= dp_in;
      r_pending <= 1'b1;
    end
  end

  assign pending = r_pending;

  // --------------------------------------------------------------------------
  // Brightness gate
  // --------------------------------------------------------------------------
`ifdef SEVSEG_PWM_EN
  // Lit for sub-steps 0..bright, i.e. (bright+1)*DIV cycles per slot
  assign w_gate = (r_sub <= bright);
`else
  assign w_gate = 1'b1;
  logic w_unused_bright;
  assign w_unused_bright = ^bright;
`endif

  // --------------------------------------------------------------------------
  // Select the current digit's data. A compare loop is used instead of direct
  // indexing so any NUM_DIGITS (including 1 and non-powers-of-two) is safe.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nib       = 4'h0;
    w_dp        = 1'b0;
    w_anode_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib          = r_act_val[4*i +: 4];
        w_dp           = r_act_dp[i];
        w_anode_nxt[i] = ~(digit_en[i] & w_gate);
      end
    end
  end

  // Segments and DP are driven every slot, even for disabled digits; only the
  // anode is suppressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_anode <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
    end else begin
      r_anode <= w_anode_nxt;
      r_seg   <= seg_decode(w_nib);
      r_dp_n  <= ~w_dp;
    end
  end

  assign anode = r_anode;
  assign seg   = r_seg;
  assign dp_n  = r_dp_n;

endmodule
`default_nettype wire
